// File: rtl/beacon_sequencer_if.sv
// rtl/beacon_sequencer_if.sv - symbol ROM bus between the beacon sequencer and its ROM
// The ROM is synchronous: rom_data follows rom_addr by one sys_clk cycle.
interface beacon_sequencer_if #(
    parameter int ADDR_W = 6
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/beacon_sequencer.sv
// rtl/beacon_sequencer.sv - beacon frame scheduler: Morse CW ID, silent gap, CP-FSK burst, holdoff
// Key line, modulator reset and burst flag are registered; frame_done is decoded from the HOLD timer.
module beacon_sequencer #(
    parameter int DIT_DIV       = 792000,
    parameter int ADDR_W        = 6,
    parameter int GAP_UNITS     = 7,
    parameter int FSK_BITS      = 1024,
    parameter int HOLDOFF_UNITS = 14
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    beacon_sequencer_if.master  rom,
    input  logic                fsk_bit_tick,
    output logic                key_out,
    output logic                cpfsk_rst,
    output logic                fsk_active,
    output logic [2:0]          state_o,
    output logic                frame_done
);
    localparam int PRE_W  = (DIT_DIV > 1) ? $clog2(DIT_DIV) : 1;
    localparam int UNIT_W = 8;
    localparam int BIT_W  = $clog2(FSK_BITS + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(DIT_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(FSK_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        KEY   = 3'd2,
        SPACE = 3'd3,
        GAP   = 3'd4,
        FSK   = 3'd5,
        HOLD  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                fetch_q, fetch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PRE_W-1:0]    pre_q, pre_d, adv_pre;
    logic [UNIT_W-1:0]   unit_q, unit_d, adv_unit;
    logic [UNIT_W-1:0]   tgt_q, tgt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                key_d, crst_d, fa_d;
    logic                unit_tick, timer_done;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            fetch_q    <= 1'b0;
            addr_q     <= '0;
            pre_q      <= '0;
            unit_q     <= '0;
            tgt_q      <= '0;
            bit_q      <= '0;
            key_out    <= 1'b0;
            cpfsk_rst  <= 1'b1;
            fsk_active <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_q    <= fetch_d;
            addr_q     <= addr_d;
            pre_q      <= pre_d;
            unit_q     <= unit_d;
            tgt_q      <= tgt_d;
            bit_q      <= bit_d;
            key_out    <= key_d;
            cpfsk_rst  <= crst_d;
            fsk_active <= fa_d;
        end
    end

    // Timed states run for tgt_q units; leaving any state clears prescaler and unit count.
    assign unit_tick  = (pre_q == PRE_MAX);
    assign timer_done = unit_tick && (unit_q == tgt_q - 8'd1);
    assign adv_pre    = unit_tick ? '0 : pre_q + 1'b1;
    assign adv_unit   = unit_tick ? unit_q + 8'd1 : unit_q;

    always_comb begin
        state_d    = state_q;
        fetch_d    = 1'b0;
        addr_d     = addr_q;
        pre_d      = '0;
        unit_d     = '0;
        tgt_d      = tgt_q;
        bit_d      = bit_q;
        key_d      = key_out;
        crst_d     = cpfsk_rst;
        fa_d       = fsk_active;
        frame_done = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            addr_d  = '0;
            tgt_d   = '0;
            bit_d   = '0;
            key_d   = 1'b0;
            crst_d  = 1'b1;
            fa_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
                FETCH: begin
                    // First cycle lets the ROM register the address; second cycle decodes.
                    if (!fetch_q) begin
                        fetch_d = 1'b1;
                    end else begin
                        case (rom.rom_data)
                            2'b00: begin
                                state_d = KEY;
                                key_d   = 1'b1;
                                tgt_d   = 8'd1;
                            end
                            2'b01: begin
                                state_d = KEY;
                                key_d   = 1'b1;
                                tgt_d   = 8'd3;
                            end
                            2'b10: begin
                                state_d = SPACE;
                                tgt_d   = 8'd2;
                            end
                            default: begin
                                state_d = GAP;
                                tgt_d   = UNIT_W'(GAP_UNITS);
                            end
                        endcase
                    end
                end
                KEY: begin
                    if (timer_done) begin
                        key_d   = 1'b0;
                        state_d = SPACE;
                        tgt_d   = 8'd1;
                    end else begin
                        pre_d  = adv_pre;
                        unit_d = adv_unit;
                    end
                end
                SPACE: begin
                    if (timer_done) begin
                        if (addr_q == ADDR_MAX) begin
                            addr_d  = '0;
                            state_d = GAP;
                            tgt_d   = UNIT_W'(GAP_UNITS);
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        pre_d  = adv_pre;
                        unit_d = adv_unit;
                    end
                end
                GAP: begin
                    if (timer_done) begin
                        state_d = FSK;
                        crst_d  = 1'b0;
                        fa_d    = 1'b1;
                    end else begin
                        pre_d  = adv_pre;
                        unit_d = adv_unit;
                    end
                end
                FSK: begin
                    if (fsk_bit_tick) begin
                        if (bit_q == BIT_MAX) begin
                            bit_d   = '0;
                            crst_d  = 1'b1;
                            fa_d    = 1'b0;
                            state_d = HOLD;
                            tgt_d   = UNIT_W'(HOLDOFF_UNITS);
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (timer_done) begin
                        frame_done = 1'b1;
                        addr_d     = '0;
                        state_d    = FETCH;
                    end else begin
                        pre_d  = adv_pre;
                        unit_d = adv_unit;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rom.rom_addr = addr_q;
    assign state_o      = state_q;
endmodule
